// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: default 640x480@60 raster timing, derived totals and sync windows,
// plus the vga_control bit-field layout shared with the pixel colour stage.
package vga_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Sync windows, inclusive on both ends.
  localparam int HSYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int HSYNC_END_DEF   = HSYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int VSYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int VSYNC_END_DEF   = VSYNC_START_DEF + V_SYNC_DEF - 1;

  // vga_control byte fields
  localparam int CTRL_BG_SEL_LSB  = 0;
  localparam int CTRL_BG_SEL_MSB  = 3;
  localparam int CTRL_BG_AUTO     = 4;
  localparam int CTRL_SPRITE_SEL  = 5;

  // Inclusive window test on a 10-bit raster coordinate.
  function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis: counts 0..TOTAL-1 when en is high and
// flags the wrap. The next value is exported so the parent can register
// decoded outputs that line up with the counter itself.
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count and wrap flag; hold when not enabled.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing, line/frame strobes, frame counter and a
// frame-synchronous shadow of the vga_control byte.
// Optional macro VGA_PIXEL_CE_EN adds a pix_ce input so the raster advances
// only on enabled cycles (e.g. 2x system clock).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY       = H_DISPLAY_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_DISPLAY       = V_DISPLAY_DEF,
  parameter int V_FRONT         = V_FRONT_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BACK          = V_BACK_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef VGA_PIXEL_CE_EN
  input  logic       pix_ce,
`endif
  input  logic [7:0] ctrl_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] frame_count,
  output logic [7:0] ctrl_latched
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Raster coordinates are 10 bits wide; larger totals cannot be represented.
  if (H_TOTAL > 1024) begin : g_h_illegal
    $error("vga_timing_gen: H_TOTAL=%0d exceeds 1024", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_v_illegal
    $error("vga_timing_gen: V_TOTAL=%0d exceeds 1024", V_TOTAL);
  end

  logic ce;
`ifdef VGA_PIXEL_CE_EN
  assign ce = pix_ce;
`else
  assign ce = 1'b1;
`endif

  logic [9:0] h_cnt, h_nxt, v_cnt, v_nxt;
  logic       h_wrap, v_wrap, frame_wrap;

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(10)) u_hcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ce),
    .cnt     (h_cnt),
    .cnt_nxt (h_nxt),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .W(10)) u_vcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (h_wrap),
    .cnt     (v_cnt),
    .cnt_nxt (v_nxt),
    .wrap    (v_wrap)
  );

  // v_wrap can only fire on an h wrap, so it already marks the frame wrap.
  assign frame_wrap = v_wrap;

  logic       hsync_q, hsync_d, vsync_q, vsync_d, visible_q, visible_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [9:0] frame_count_q, frame_count_d;
  logic [7:0] ctrl_q, ctrl_d;

  // Decode from the next coordinates so outputs align with hpos/vpos.
  always_comb begin
    hsync_d       = in_window(h_nxt, HS_START, HS_END) ^ SYNC_ACTIVE_LOW;
    vsync_d       = in_window(v_nxt, VS_START, VS_END) ^ SYNC_ACTIVE_LOW;
    visible_d     = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    line_start_d  = h_wrap;
    frame_start_d = frame_wrap;
    frame_count_d = frame_count_q + 10'(frame_wrap);
    ctrl_d        = frame_wrap ? ctrl_in : ctrl_q;
  end

  // Output registers; reset aborts any sync pulse in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q       <= SYNC_ACTIVE_LOW;
      vsync_q       <= SYNC_ACTIVE_LOW;
      visible_q     <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      ctrl_q        <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      ctrl_q        <= ctrl_d;
    end
  end

  assign hpos         = h_cnt;
  assign vpos         = v_cnt;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign visible      = visible_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign frame_count  = frame_count_q;
  assign ctrl_latched = ctrl_q;

endmodule
